// File: rtl/microstep_hbridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : microstep_hbridge
// Purpose  : Step/dir to sin/cos microstep position with current-scaled PWM
//            driving two H-bridge phase pin pairs, idle hold and fault latch.
// Revision : 1.0 - initial release
// ============================================================================
module microstep_hbridge #(
    parameter int PHASE_BITS      = 10,
    parameter int AMP_BITS        = 8,
    parameter int CURRENT_BITS    = 8,
    parameter int PWM_BITS        = 10,
    parameter int STEP_COUNT_BITS = 32,
    parameter int IDLE_BITS       = 24
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       step,
    input  logic                       dir,
    input  logic                       enable,
    input  logic                       brake,
    input  logic                       slow_decay,
    input  logic [3:0]                 microstep_shift,
    input  logic [CURRENT_BITS-1:0]    run_current,
    input  logic [CURRENT_BITS-1:0]    hold_current,
    input  logic [IDLE_BITS-1:0]       idle_timeout,
    input  logic                       fault,
    input  logic                       fault_clear,
    output logic                       phase_a1,
    output logic                       phase_a2,
    output logic                       phase_b1,
    output logic                       phase_b2,
    output logic                       vref_a,
    output logic                       vref_b,
    output logic [PHASE_BITS-1:0]      phase,
    output logic [STEP_COUNT_BITS-1:0] step_count,
    output logic                       hold_active,
    output logic                       fault_latched
);

    localparam int         c_IDX_BITS  = PHASE_BITS - 2;
    localparam int         c_Q         = 2 ** c_IDX_BITS;
    localparam int         c_PROD_BITS = AMP_BITS + CURRENT_BITS;
    localparam int         c_SHIFT     = c_PROD_BITS - PWM_BITS;
    localparam logic [3:0] c_MS_MAX    = 4'(PHASE_BITS - 2);
    localparam real        c_PI        = 3.14159265358979323846;
    localparam real        c_AMAX      = real'((2 ** AMP_BITS) - 1);

    // Quarter-wave cosine table, resolved entirely at elaboration.
    logic [AMP_BITS-1:0] w_rom [c_Q];
    for (genvar gi = 0; gi < c_Q; gi++) begin : g_rom
        localparam int c_VAL = $rtoi(c_AMAX * $cos(c_PI / 2.0 * real'(gi) / real'(c_Q)) + 0.5);
        assign w_rom[gi] = AMP_BITS'(c_VAL);
    end

    logic                       r_sync1, r_sync2, r_prev, r_edge;
    logic [PHASE_BITS-1:0]      r_phase;
    logic [STEP_COUNT_BITS-1:0] r_count;
    logic [IDLE_BITS-1:0]       r_idle;
    logic                       r_hold;
    logic                       r_fault;
    logic [CURRENT_BITS-1:0]    r_cur;
    logic [PWM_BITS-1:0]        r_cnt;

    logic                       w_accept;
    logic [3:0]                 w_ms_eff;
    logic [PHASE_BITS-1:0]      w_inc;
    logic [IDLE_BITS-1:0]       w_idle_next;

    assign w_accept = r_edge & ~r_fault;
    assign w_ms_eff = (microstep_shift > c_MS_MAX) ? c_MS_MAX : microstep_shift;
    assign w_inc    = PHASE_BITS'(1) << (c_MS_MAX - w_ms_eff);

    always_comb begin
        w_idle_next = r_idle;
        if (w_accept)
            w_idle_next = '0;
        else if (r_idle >= idle_timeout)
            w_idle_next = idle_timeout;
        else
            w_idle_next = r_idle + IDLE_BITS'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
            r_edge  <= 1'b0;
            r_phase <= '0;
            r_count <= '0;
            r_idle  <= '0;
            r_hold  <= 1'b0;
            r_fault <= 1'b0;
            r_cur   <= '0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= step;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
            r_edge  <= r_sync2 & ~r_prev;
            if (w_accept) begin
                r_phase <= dir ? (r_phase + w_inc) : (r_phase - w_inc);
                r_count <= dir ? (r_count + STEP_COUNT_BITS'(1)) : (r_count - STEP_COUNT_BITS'(1));
            end
            r_idle <= w_idle_next;
            // Evaluated on the next counter value so an accepted step always wins.
            r_hold <= (w_idle_next == idle_timeout) && (idle_timeout != '0);
            if (fault)
                r_fault <= 1'b1;
            else if (fault_clear)
                r_fault <= 1'b0;
            r_cur <= r_hold ? hold_current : run_current;
            r_cnt <= r_cnt + PWM_BITS'(1);
        end
    end

    logic [1:0] w_vref_q, w_pin1_q, w_pin2_q;

    // Channel 0 is phase A, channel 1 is phase B lagging by a full step.
    for (genvar gc = 0; gc < 2; gc++) begin : g_ch
        localparam logic [PHASE_BITS-1:0] c_OFF = (gc == 0) ? '0 : PHASE_BITS'(c_Q);

        logic [PHASE_BITS-1:0]  w_p;
        logic [1:0]             w_q;
        logic [c_IDX_BITS-1:0]  w_i;
        logic [AMP_BITS-1:0]    w_amp;
        logic [c_PROD_BITS-1:0] w_prod;
        logic                   w_vref;
        logic [AMP_BITS-1:0]    r_amp;
        logic                   r_neg_amp;
        logic [PWM_BITS-1:0]    r_duty;
        logic                   r_neg_duty;
        logic                   r_vref, r_pin1, r_pin2;

        assign w_p = r_phase - c_OFF;
        assign w_q = w_p[PHASE_BITS-1 -: 2];
        assign w_i = w_p[c_IDX_BITS-1:0];

        always_comb begin
            w_amp = w_rom[w_i];
            if (w_q[0])
                w_amp = (w_i == '0) ? '0 : w_rom[c_IDX_BITS'(0) - w_i];
        end

        assign w_prod = c_PROD_BITS'(r_amp) * c_PROD_BITS'(r_cur);
        assign w_vref = r_duty > r_cnt;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_amp      <= '0;
                r_neg_amp  <= 1'b0;
                r_duty     <= '0;
                r_neg_duty <= 1'b0;
                r_vref     <= 1'b0;
                r_pin1     <= 1'b0;
                r_pin2     <= 1'b0;
            end else begin
                r_amp      <= w_amp;
                r_neg_amp  <= w_q[0] ^ w_q[1];
                r_duty     <= PWM_BITS'(w_prod >> c_SHIFT);
                r_neg_duty <= r_neg_amp;
                r_vref     <= w_vref;
                if (r_fault) begin
                    r_pin1 <= 1'b0;
                    r_pin2 <= 1'b0;
                end else if (!enable) begin
                    r_pin1 <= brake;
                    r_pin2 <= brake;
                end else if (w_vref) begin
                    r_pin1 <= ~r_neg_duty;
                    r_pin2 <= r_neg_duty;
                end else begin
                    r_pin1 <= slow_decay;
                    r_pin2 <= slow_decay;
                end
            end
        end

        assign w_vref_q[gc] = r_vref;
        assign w_pin1_q[gc] = r_pin1;
        assign w_pin2_q[gc] = r_pin2;
    end

    assign phase_a1      = w_pin1_q[0];
    assign phase_a2      = w_pin2_q[0];
    assign phase_b1      = w_pin1_q[1];
    assign phase_b2      = w_pin2_q[1];
    assign vref_a        = w_vref_q[0];
    assign vref_b        = w_vref_q[1];
    assign phase         = r_phase;
    assign step_count    = r_count;
    assign hold_active   = r_hold;
    assign fault_latched = r_fault;

endmodule
`default_nettype wire

// File: tb/tb_microstep_hbridge.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_microstep_hbridge
// Purpose  : Self-checking bench for microstep_hbridge against a sin/cos model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_microstep_hbridge;

    localparam int  c_N      = 1024;
    localparam real c_PI     = 3.14159265358979323846;

    logic        clk = 1'b0;
    logic        reset, step, dir, enable, brake, slow_decay, fault, fault_clear;
    logic [3:0]  microstep_shift;
    logic [7:0]  run_current, hold_current;
    logic [23:0] idle_timeout;
    logic        phase_a1, phase_a2, phase_b1, phase_b2, vref_a, vref_b;
    logic [9:0]  phase;
    logic [31:0] step_count;
    logic        hold_active, fault_latched;

    int n_checks = 0;
    int n_errors = 0;

    int m_phase = 0;
    int m_count = 0;
    bit m_hold  = 1'b0;
    bit m_fault = 1'b0;

    microstep_hbridge dut (
        .clk(clk), .reset(reset), .step(step), .dir(dir), .enable(enable),
        .brake(brake), .slow_decay(slow_decay), .microstep_shift(microstep_shift),
        .run_current(run_current), .hold_current(hold_current),
        .idle_timeout(idle_timeout), .fault(fault), .fault_clear(fault_clear),
        .phase_a1(phase_a1), .phase_a2(phase_a2), .phase_b1(phase_b1),
        .phase_b2(phase_b2), .vref_a(vref_a), .vref_b(vref_b), .phase(phase),
        .step_count(step_count), .hold_active(hold_active),
        .fault_latched(fault_latched)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Winding current follows cos (A) and sin (B) of the electrical angle.
    function automatic real m_wave(input int p, input bit chb);
        real a;
        a = 2.0 * c_PI * real'(p) / real'(c_N);
        return chb ? $sin(a) : $cos(a);
    endfunction

    function automatic int m_duty(input int p, input bit chb, input int cur);
        real c;
        int  amp;
        c = m_wave(p, chb);
        if (c < 0.0) c = -c;
        amp = $rtoi(255.0 * c + 0.5);
        return (amp * cur) / 64;
    endfunction

    function automatic void m_step(input bit d, input int ms);
        int inc;
        if (m_fault) return;
        inc = 1 << (8 - ((ms > 8) ? 8 : ms));
        m_phase = (m_phase + (d ? inc : c_N - inc)) % c_N;
        m_count = d ? m_count + 1 : m_count - 1;
        m_hold  = 1'b0;
    endfunction

    task automatic pulse_step(input bit d);
        @(negedge clk);
        dir  = d;
        step = 1'b1;
        repeat (2) @(negedge clk);
        step = 1'b0;
        repeat (3) @(negedge clk);
        m_step(d, int'(microstep_shift));
    endtask

    task automatic check_state(input string tag);
        int cur, d, e1, e2, off;
        int cnt_v [2];
        int cnt_1 [2];
        int cnt_2 [2];
        bit neg;
        repeat (12) @(negedge clk);
        chk({tag, ".phase"}, 32'(phase), m_phase);
        chk({tag, ".count"}, step_count, m_count);
        chk({tag, ".hold"}, 32'(hold_active), 32'(m_hold));
        chk({tag, ".fault"}, 32'(fault_latched), 32'(m_fault));
        for (int c = 0; c < 2; c++) begin
            cnt_v[c] = 0; cnt_1[c] = 0; cnt_2[c] = 0;
        end
        for (int k = 0; k < c_N; k++) begin
            @(negedge clk);
            cnt_v[0] += int'(vref_a);   cnt_v[1] += int'(vref_b);
            cnt_1[0] += int'(phase_a1); cnt_1[1] += int'(phase_b1);
            cnt_2[0] += int'(phase_a2); cnt_2[1] += int'(phase_b2);
        end
        cur = m_hold ? int'(hold_current) : int'(run_current);
        for (int c = 0; c < 2; c++) begin
            d   = m_duty(m_phase, c[0], cur);
            neg = m_wave(m_phase, c[0]) < 0.0;
            off = c_N - d;
            if (m_fault) begin
                e1 = 0; e2 = 0;
            end else if (!enable) begin
                e1 = brake ? c_N : 0; e2 = e1;
            end else begin
                e1 = (neg ? 0 : d) + (slow_decay ? off : 0);
                e2 = (neg ? d : 0) + (slow_decay ? off : 0);
            end
            chk($sformatf("%s.vref%0d", tag, c), cnt_v[c], d);
            chk($sformatf("%s.pin1_%0d", tag, c), cnt_1[c], e1);
            chk($sformatf("%s.pin2_%0d", tag, c), cnt_2[c], e2);
        end
    endtask

    initial begin
        reset = 1'b1; step = 1'b0; dir = 1'b1; enable = 1'b0; brake = 1'b0;
        slow_decay = 1'b0; fault = 1'b0; fault_clear = 1'b0;
        microstep_shift = 4'd0; run_current = 8'd0; hold_current = 8'd0;
        idle_timeout = 24'd0;

        // Reset with step toggling underneath.
        repeat (3) begin
            @(negedge clk);
            step = ~step;
        end
        @(negedge clk);
        chk("rst.pins", 32'({phase_a1, phase_a2, phase_b1, phase_b2}), 0);
        chk("rst.vref", 32'({vref_a, vref_b}), 0);
        chk("rst.phase", 32'(phase), 0);
        chk("rst.count", step_count, 0);
        chk("rst.hold", 32'(hold_active), 0);
        chk("rst.fault", 32'(fault_latched), 0);
        step  = 1'b0;
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // Step-to-phase latency: first high at edge N, update at edge N+3.
        enable = 1'b1; run_current = 8'd255; dir = 1'b1;
        @(negedge clk); step = 1'b1;
        @(negedge clk);
        @(negedge clk); step = 1'b0;
        @(negedge clk);
        chk("lat.n2", 32'(phase), 0);
        @(negedge clk);
        chk("lat.n3", 32'(phase), 256);
        m_step(1'b1, 0);
        check_state("fs1");
        for (int s = 0; s < 3; s++) begin
            pulse_step(1'b1);
            check_state($sformatf("fs%0d", s + 2));
        end

        repeat (4) pulse_step(1'b0);
        chk("back.phase", 32'(phase), m_phase);
        chk("back.count", step_count, m_count);

        microstep_shift = 4'd8;
        pulse_step(1'b0);
        chk("ms8.phase", 32'(phase), 1023);
        chk("ms8.count", step_count, 32'hFFFF_FFFF);
        check_state("ms8");

        microstep_shift = 4'd12;
        pulse_step(1'b1);
        check_state("clamp");

        run_current = 8'd0; slow_decay = 1'b1;
        check_state("zero_cur");
        enable = 1'b0; brake = 1'b1;
        check_state("brake");

        // Idle timeout to hold current.
        enable = 1'b1; brake = 1'b0; slow_decay = 1'b0;
        run_current = 8'd200; hold_current = 8'd50; idle_timeout = 24'd100;
        microstep_shift = 4'd8; dir = 1'b1;
        @(negedge clk); step = 1'b1;
        @(negedge clk);
        @(negedge clk); step = 1'b0;
        @(negedge clk);
        @(negedge clk);
        m_step(1'b1, 8);
        repeat (99) @(negedge clk);
        chk("idle.99", 32'(hold_active), 0);
        @(negedge clk);
        chk("idle.100", 32'(hold_active), 1);
        m_hold = 1'b1;
        check_state("hold");
        pulse_step(1'b1);
        chk("hold.clear", 32'(hold_active), 0);
        idle_timeout = 24'd0;
        check_state("unhold");

        // Fault latch, ignored steps, clear handshake.
        run_current = 8'd255; slow_decay = 1'b1;
        repeat (8) @(negedge clk);
        @(negedge clk); fault = 1'b1;
        @(negedge clk);
        chk("flt.latch", 32'(fault_latched), 1);
        @(negedge clk);
        chk("flt.pins", 32'({phase_a1, phase_a2, phase_b1, phase_b2}), 0);
        m_fault = 1'b1;
        pulse_step(1'b1);
        pulse_step(1'b0);
        pulse_step(1'b1);
        chk("flt.count", step_count, m_count);
        chk("flt.phase", 32'(phase), m_phase);
        fault_clear = 1'b1;
        @(negedge clk); fault_clear = 1'b0;
        @(negedge clk);
        chk("flt.clr_busy", 32'(fault_latched), 1);
        fault = 1'b0;
        repeat (2) @(negedge clk);
        chk("flt.hold", 32'(fault_latched), 1);
        fault_clear = 1'b1;
        @(negedge clk); fault_clear = 1'b0;
        @(negedge clk);
        chk("flt.cleared", 32'(fault_latched), 0);
        m_fault = 1'b0;
        check_state("resume");

        // Randomized operating points.
        for (int it = 0; it < 12; it++) begin
            microstep_shift = 4'($urandom_range(0, 15));
            enable      = ($urandom_range(0, 3) != 0);
            brake       = 1'($urandom);
            slow_decay  = 1'($urandom);
            run_current = 8'($urandom);
            for (int s = 0; s < int'($urandom_range(1, 3)); s++)
                pulse_step(1'($urandom));
            check_state($sformatf("rnd%0d", it));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/microstep_hbridge.md
# microstep_hbridge

Parametrised single-clock successor to the dual H-bridge stepper driver. It converts step/dir pulses into a sin/cos phase position and current-scaled PWM. It drives two bridge-phase pin pairs, selectable decay, idle current reduction and a latched fault shutdown. It sits between the step generator and the external bridge pins, and on its own clock replaces the separate PWM clock domain.

## Interface
- PHASE_BITS, 10, electrical-cycle resolution; N=2^PHASE_BITS positions, quarter Q=N/4 = one full step
- AMP_BITS, 8, sine amplitude width
- CURRENT_BITS, 8, current scale width
- PWM_BITS, 10, PWM counter/duty width; must be ≤ AMP_BITS+CURRENT_BITS
- STEP_COUNT_BITS, 32, signed step counter width
- IDLE_BITS, 24, idle timer width
- clk  in  1  sole clock
- reset  in  1  synchronous, active-high
- step  in  1  asynchronous step pulse; rising edge advances
- dir  in  1  1 = forward (+), 0 = reverse (−)
- enable  in  1  bridge enable
- brake  in  1  when disabled: 1 = both pins high, 0 = both low
- slow_decay  in  1  PWM-off state: 1 = both high, 0 = both low
- microstep_shift  in  4  microsteps per full step = 2^ms; clamped to PHASE_BITS−2
- run_current  in  CURRENT_BITS  current while moving
- hold_current  in  CURRENT_BITS  current after idle timeout
- idle_timeout  in  IDLE_BITS  cycles without step before hold; 0 disables
- fault  in  1  external fault, level
- fault_clear  in  1  single-cycle clear request
- phase_a1, phase_a2, phase_b1, phase_b2  out  1 each  bridge pins
- vref_a, vref_b  out  1 each  PWM references
- phase  out  PHASE_BITS  current electrical position
- step_count  out  STEP_COUNT_BITS  signed step-pulse count
- hold_active  out  1  hold current in use
- fault_latched  out  1  fault shutdown active

## Operation
- Step path: 2-flop synchroniser, then edge register. A rising edge with fault_latched=0 applies two updates:
  - phase += dir ? inc : −inc, mod N, where inc = 2^(PHASE_BITS−2−ms).
  - step_count ±1, two's-complement wrap.
- Steps are ignored while fault_latched. They are counted while enable=0.
- Amplitude: quarter-wave ROM with Q entries, entry i = round((2^AMP_BITS−1)·cos(π/2·i/Q)).
- Phase A uses p=phase; phase B uses p=phase−Q. Let quadrant q=p[top 2] and index i=p[low].
  - Amplitude is ROM[i] for q even, and ROM[Q−i] for q odd. For odd q with i=0, amplitude = 0.
  - Sign is negative for q=1,2.
- Duty = (amp·cur) >> (AMP_BITS+CURRENT_BITS−PWM_BITS), where cur = hold_active ? hold_current : run_current.
- PWM: free-running PWM_BITS counter cnt, wrapping. vref_x = (duty_x > cnt).
- Pin drive, in priority order:
  1. fault_latched → all four pins 0.
  2. enable=0 → all four = brake.
  3. vref_x=1 → polarity: positive gives x1=1,x2=0; negative gives x1=0,x2=1.
  4. vref_x=0 → both pins = slow_decay.
- Idle: the counter clears on every accepted step edge. Otherwise it increments, saturating at idle_timeout.
  - hold_active=1 when counter == idle_timeout ≠ 0.
  - A step edge clears hold_active on the following cycle.
  - If a step edge and timeout occur in the same cycle, the step wins.
- Fault: fault=1 sets fault_latched. fault_clear with fault=0 clears it. Simultaneous fault and fault_clear keep it set.
- Reset: every register goes to 0 on the next edge, including mid-step or mid-PWM. All outputs are then 0.

## Timing
- All outputs registered.
- If step is first high at edge N, phase/step_count update at edge N+3.
- Amplitude is registered at N+4 and duty at N+5. New duty is reflected in vref/pins from edge N+6.
- hold_active is registered; cur switches one cycle after hold_active changes.
- fault → pins 0 at the second edge after fault is sampled (latch, then output register).
- PWM period is 2^PWM_BITS cycles. Duty=0 gives vref constantly 0. Max duty gives vref low 1 cycle per period.

## Test plan
- Reset: hold reset 3 cycles with step toggling → all pins, vref, phase, step_count, hold_active, fault_latched = 0.
- ms=0, dir=1, four steps from 0 → phase 256, 512, 768, 0; step_count 4. Phase A sign is −, −, +, + after each step. Phase A pins settle 3 edges after each phase update.
- ms=8, dir=0, one step from 0 → phase 1023, step_count all-ones (−1). A amplitude = ROM[1] with positive sign; B amplitude = ROM[255] with negative sign.
- run_current=255, phase 0, enable=1 → duty_a=1016; vref_a high 1016 of 1024 cycles. run_current=0 → vref_a never high; pins follow slow_decay.
- idle_timeout=100, run_current=200, hold_current=50 → hold_active rises exactly 100 counted cycles after the last accepted edge, and duty drops. The next step clears hold_active.
- Fault pulse while stepping:
  - Pins go to 0 within 2 cycles and steps stop counting.
  - fault_clear while fault=1 → stays latched.
  - fault_clear after fault=0 → resumes at the held phase.
